// File: rtl/wordle_guess_scorer.sv
// Scores a latched guess against a latched target: green pass, then a yellow/gray pass that
// consumes duplicate target letters. Result, Win, Busy and Done are all registered.
module wordle_guess_scorer #(
    parameter int unsigned NUM_LETTERS = 5,
    parameter int unsigned LETTER_W    = 8
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          Start,
    input  logic [NUM_LETTERS*LETTER_W-1:0] guessWord,
    input  logic [NUM_LETTERS*LETTER_W-1:0] randomWord,
    output logic                          Busy,
    output logic                          Done,
    output logic [2*NUM_LETTERS-1:0]      Result,
    output logic                          Win
);

    localparam int unsigned WORD_W = NUM_LETTERS * LETTER_W;
    localparam int unsigned IDX_W  = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LETTERS - 1);

    localparam logic [1:0] COL_GRAY   = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;

    typedef enum logic [1:0] {StIdle, StGreen, StYellow, StDone} state_e;

    state_e                   state_q, state_d;
    logic [WORD_W-1:0]        g_q, g_d;
    logic [WORD_W-1:0]        t_q, t_d;
    logic [IDX_W-1:0]         index_q, index_d;
    logic [NUM_LETTERS-1:0]   consumed_q, consumed_d;
    logic [1:0]               res_q [NUM_LETTERS];
    logic [1:0]               res_d [NUM_LETTERS];
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     win_q, win_d;

    logic [LETTER_W-1:0]      g_let [NUM_LETTERS];
    logic [LETTER_W-1:0]      t_let [NUM_LETTERS];
    logic [LETTER_W-1:0]      cur_g;
    logic                     found;
    logic [IDX_W-1:0]         match_idx;
    logic                     all_green;

    // Letter 0 lives in the most significant byte of each word.
    always_comb begin
        for (int i = 0; i < NUM_LETTERS; i++) begin
            g_let[i] = g_q[(NUM_LETTERS - 1 - i) * LETTER_W +: LETTER_W];
            t_let[i] = t_q[(NUM_LETTERS - 1 - i) * LETTER_W +: LETTER_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        t_d        = t_q;
        index_d    = index_q;
        consumed_d = consumed_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        win_d      = win_q;
        cur_g      = g_let[index_q];
        found      = 1'b0;
        match_idx  = '0;
        all_green  = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    g_d        = guessWord;
                    t_d        = randomWord;
                    res_d      = '{default: COL_GRAY};
                    win_d      = 1'b0;
                    consumed_d = '0;
                    index_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = StGreen;
                end
            end
            StGreen: begin
                if (cur_g == t_let[index_q] && cur_g != '0) begin
                    res_d[index_q]      = COL_GREEN;
                    consumed_d[index_q] = 1'b1;
                end
                if (index_q == LAST_IDX) begin
                    index_d = '0;
                    state_d = StYellow;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            StYellow: begin
                if (res_q[index_q] != COL_GREEN && cur_g != '0) begin
                    // Lowest unconsumed matching target position wins.
                    for (int j = 0; j < NUM_LETTERS; j++) begin
                        if (!found && !consumed_q[j] && t_let[j] == cur_g) begin
                            found     = 1'b1;
                            match_idx = IDX_W'(j);
                        end
                    end
                    if (found) begin
                        res_d[index_q]        = COL_YELLOW;
                        consumed_d[match_idx] = 1'b1;
                    end
                end
                if (index_q == LAST_IDX) begin
                    for (int k = 0; k < NUM_LETTERS; k++) begin
                        if (res_d[k] != COL_GREEN) all_green = 1'b0;
                    end
                    win_d   = all_green;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    index_d = '0;
                    state_d = StDone;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= StIdle;
            g_q        <= '0;
            t_q        <= '0;
            index_q    <= '0;
            consumed_q <= '0;
            res_q      <= '{default: COL_GRAY};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            t_q        <= t_d;
            index_q    <= index_d;
            consumed_q <= consumed_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            win_q      <= win_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LETTERS; i++) begin
            Result[2 * (NUM_LETTERS - 1 - i) +: 2] = res_q[i];
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Win  = win_q;

endmodule
